// File: rtl/word_serializer_tx.sv
// Word serializer: takes parallel words on a valid/ready handshake and shifts them out LSB-first on bit_out.
// Latency: bit 0 appears on bit_out one cycle after the handshake; a frame is LAST+1 contiguous bit_valid cycles.
// Backpressure: din_ready depends only on state and counters; it is high in IDLE, on the last frame bit when GAP==0, and in the final gap cycle.
// Optional: define WORD_SERIALIZER_PARITY_EN to append an even-parity bit after bit WIDTH-1.
module word_serializer_tx #(
   parameter int   WIDTH    = 14,
   parameter int   GAP      = 0,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             frame_done,
   output logic             busy
);

`ifdef WORD_SERIALIZER_PARITY_EN
   localparam int SW = WIDTH + 1;
`else
   localparam int SW = WIDTH;
`endif
   // LAST is the index of the final bit of a frame (the parity bit when enabled)
   localparam int LAST = SW - 1;
   localparam int CW   = $clog2(LAST + 1);
   localparam int GW   = (GAP < 2) ? 1 : $clog2(GAP);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   sreg_q, sreg_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [GW-1:0]   gcnt_q, gcnt_d;
   logic            bit_out_q, bit_out_d;
   logic            bit_valid_q, bit_valid_d;
   logic            frame_start_q, frame_start_d;
   logic            frame_done_q, frame_done_d;
   logic            busy_q, busy_d;
   logic            load;
   logic [SW-1:0]   load_word;

   // Word as it enters the shift register; parity is fixed at load time
`ifdef WORD_SERIALIZER_PARITY_EN
   assign load_word = {^din, din};
`else
   assign load_word = din;
`endif

   // Ready is a pure decode of the registered state and counters
   always_comb begin
      din_ready = 1'b0;
      case (state_q)
         ST_IDLE:  din_ready = 1'b1;
         ST_SHIFT: din_ready = (GAP == 0) && (cnt_q == CW'(LAST));
         ST_GAP:   din_ready = (gcnt_q == '0);
         default:  din_ready = 1'b0;
      endcase
   end

   // Next-state and next-output computation; all outputs are registered from these
   always_comb begin
      state_d       = state_q;
      sreg_d        = sreg_q;
      cnt_d         = cnt_q;
      gcnt_d        = gcnt_q;
      bit_out_d     = IDLE_BIT;
      bit_valid_d   = 1'b0;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;
      load          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (din_valid) load = 1'b1;
         end
         ST_SHIFT: begin
            if (cnt_q != CW'(LAST)) begin
               // present the next bit; done flags the final bit of the frame
               bit_out_d    = sreg_q[0];
               bit_valid_d  = 1'b1;
               sreg_d       = sreg_q >> 1;
               cnt_d        = cnt_q + CW'(1);
               frame_done_d = (cnt_q == CW'(LAST - 1));
            end else if (GAP > 0) begin
               state_d = ST_GAP;
               gcnt_d  = GW'(GAP - 1);
            end else if (din_valid) begin
               load = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gcnt_q != '0) begin
               gcnt_d = gcnt_q - GW'(1);
            end else if (din_valid) begin
               load = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Accepting a word puts bit 0 on the wire next cycle and keeps the rest in the shifter
      if (load) begin
         state_d       = ST_SHIFT;
         sreg_d        = load_word >> 1;
         cnt_d         = '0;
         bit_out_d     = din[0];
         bit_valid_d   = 1'b1;
         frame_start_d = 1'b1;
         frame_done_d  = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset drops any frame in flight without a done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         sreg_q        <= '0;
         cnt_q         <= '0;
         gcnt_q        <= '0;
         bit_out_q     <= IDLE_BIT;
         bit_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         sreg_q        <= sreg_d;
         cnt_q         <= cnt_d;
         gcnt_q        <= gcnt_d;
         bit_out_q     <= bit_out_d;
         bit_valid_q   <= bit_valid_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         busy_q        <= busy_d;
      end
   end

   assign bit_out     = bit_out_q;
   assign bit_valid   = bit_valid_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_word_serializer_tx.sv
// Bench for word_serializer_tx: two instances (GAP=0 and GAP=2) fed from word queues.
// Reference: a per-instance queue of future output symbols, filled a whole frame at a time.
// Directed patterns from the plan, then randomized words with random valid gating.
module tb_word_serializer_tx;

   localparam int W = 14;
`ifdef WORD_SERIALIZER_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FL = W + P;
   localparam int GAP1 = 2;
   localparam int MB = 64;

   typedef struct packed {
      logic b;
      logic v;
      logic s;
      logic d;
   } rec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] din0, din1;
   logic         dv0, dv1;
   logic         rdy0, rdy1, bo0, bo1, bv0, bv1, fs0, fs1, fd0, fd1, busy0, busy1;

   int vectors = 0;
   int miscompares = 0;

   rec_t mbuf [2][MB];
   int   mhead [2];
   int   mlen [2];
   logic [W-1:0] src0 [$];
   logic [W-1:0] src1 [$];
   bit   rnd_gate = 1'b0;
   logic [FL-1:0] fr0, last0;

   always #5 clk = ~clk;

   word_serializer_tx #(.WIDTH(W), .GAP(0), .IDLE_BIT(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .din(din0), .din_valid(dv0), .din_ready(rdy0),
      .bit_out(bo0), .bit_valid(bv0), .frame_start(fs0), .frame_done(fd0), .busy(busy0)
   );

   word_serializer_tx #(.WIDTH(W), .GAP(GAP1), .IDLE_BIT(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .din_ready(rdy1),
      .bit_out(bo1), .bit_valid(bv1), .frame_start(fs1), .frame_done(fd1), .busy(busy1)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic rec_t cur(input int k);
      rec_t r;
      r = '0;
      if (mlen[k] > 0) r = mbuf[k][mhead[k]];
      return r;
   endfunction

   task automatic push(input int k, input rec_t r);
      mbuf[k][(mhead[k] + mlen[k]) % MB] = r;
      mlen[k]++;
   endtask

   // A word becomes FL frame symbols followed by the instance's idle gap
   task automatic push_frame(input int k, input logic [W-1:0] w);
      logic [W:0] ext;
      rec_t r;
      ext = {^w, w};
      for (int i = 0; i < FL; i++) begin
         r.b = ext[i];
         r.v = 1'b1;
         r.s = (i == 0);
         r.d = (i == FL - 1);
         push(k, r);
      end
      for (int i = 0; i < ((k == 0) ? 0 : GAP1); i++) push(k, rec_t'(4'b0000));
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         mhead[k] = 0;
         mlen[k]  = 0;
      end
   endtask

   task automatic check_outputs(input string ph);
      rec_t r0, r1;
      r0 = cur(0);
      r1 = cur(1);
      chk_eq({ph, "/g0 bit_out"},     32'(bo0),   32'(r0.b));
      chk_eq({ph, "/g0 bit_valid"},   32'(bv0),   32'(r0.v));
      chk_eq({ph, "/g0 frame_start"}, 32'(fs0),   32'(r0.s));
      chk_eq({ph, "/g0 frame_done"},  32'(fd0),   32'(r0.d));
      chk_eq({ph, "/g0 busy"},        32'(busy0), 32'(mlen[0] > 0));
      chk_eq({ph, "/g2 bit_out"},     32'(bo1),   32'(r1.b));
      chk_eq({ph, "/g2 bit_valid"},   32'(bv1),   32'(r1.v));
      chk_eq({ph, "/g2 frame_start"}, 32'(fs1),   32'(r1.s));
      chk_eq({ph, "/g2 frame_done"},  32'(fd1),   32'(r1.d));
      chk_eq({ph, "/g2 busy"},        32'(busy1), 32'(mlen[1] > 0));
   endtask

   // One clock: drive at negedge, check ready, advance model at posedge, check outputs at next negedge
   task automatic step(input string ph);
      logic hs0, hs1;
      dv0  = (src0.size() > 0) && (!rnd_gate || ($urandom_range(0, 3) != 0));
      dv1  = (src1.size() > 0) && (!rnd_gate || ($urandom_range(0, 3) != 0));
      din0 = (dv0) ? src0[0] : W'($urandom);
      din1 = (dv1) ? src1[0] : W'($urandom);
      chk_eq({ph, "/g0 din_ready"}, 32'(rdy0), 32'(mlen[0] <= 1));
      chk_eq({ph, "/g2 din_ready"}, 32'(rdy1), 32'(mlen[1] <= 1));
      hs0 = dv0 && (mlen[0] <= 1);
      hs1 = dv1 && (mlen[1] <= 1);
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (mlen[k] > 0) begin
            mhead[k] = (mhead[k] + 1) % MB;
            mlen[k]--;
         end
      end
      if (hs0) begin
         push_frame(0, din0);
         void'(src0.pop_front());
      end
      if (hs1) begin
         push_frame(1, din1);
         void'(src1.pop_front());
      end
      @(negedge clk);
      check_outputs(ph);
      if (bv0) fr0 = {bo0, fr0[FL-1:1]};
      if (fd0) last0 = fr0;
   endtask

   task automatic run_until_idle(input string ph, input int budget);
      int n;
      n = 0;
      while ((src0.size() > 0 || src1.size() > 0 || mlen[0] > 0 || mlen[1] > 0) && n < budget) begin
         step(ph);
         n++;
      end
      step(ph);
      if (n >= budget) chk_eq({ph, " timeout"}, 32'(n), 32'(budget - 1));
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      dv0 = 1'b1;
      dv1 = 1'b1;
      src0.delete();
      src1.delete();
      model_clear();
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      dv0 = 1'b0;
      dv1 = 1'b0;
      #1;
      chk_eq("post_rst/g0 din_ready", 32'(rdy0), 32'd1);
      chk_eq("post_rst/g2 din_ready", 32'(rdy1), 32'd1);
   endtask

   initial begin
      din0 = '0;
      din1 = '0;
      fr0 = '0;
      last0 = '0;
      apply_reset();
      din0 = W'($urandom);
      din1 = W'($urandom);

      // Reset held with valid asserted: nothing may start
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs("reset");
      chk_eq("reset/g0 bit_out_level", 32'(bo0), 32'd0);
      release_reset();

      // Single word, LSB first
      src0.push_back(14'h2A5B);
      src1.push_back(14'h2A5B);
      run_until_idle("single", 200);
      chk_eq("single/g0 frame_bits", 32'(last0[W-1:0]), 32'h2A5B);
      if (P == 1) chk_eq("single/g0 parity", 32'(last0[FL-1]), 32'd0);

      // Back-to-back with valid held: GAP=0 contiguous, GAP=2 two idle cycles
      src0.push_back(14'h0000);
      src0.push_back(14'h3FFF);
      src1.push_back(14'h0000);
      src1.push_back(14'h3FFF);
      run_until_idle("b2b", 200);
      chk_eq("b2b/g0 frame_bits", 32'(last0[W-1:0]), 32'h3FFF);

      // Reset while bit 6 is on the wire
      src0.push_back(14'h2A5B);
      src1.push_back(14'h2A5B);
      repeat (7) step("pre_rst");
      chk_eq("pre_rst/g0 bit6", 32'(bo0), 32'(1'b1));
      apply_reset();
      #1;
      chk_eq("midrst/g0 bit_out",    32'(bo0),   32'd0);
      chk_eq("midrst/g0 bit_valid",  32'(bv0),   32'd0);
      chk_eq("midrst/g0 frame_done", 32'(fd0),   32'd0);
      chk_eq("midrst/g0 busy",       32'(busy0), 32'd0);
      chk_eq("midrst/g2 bit_valid",  32'(bv1),   32'd0);
      chk_eq("midrst/g2 busy",       32'(busy1), 32'd0);
      @(posedge clk);
      release_reset();
      src0.push_back(14'h0001);
      src1.push_back(14'h0001);
      run_until_idle("after_rst", 200);
      chk_eq("after_rst/g0 frame_bits", 32'(last0[W-1:0]), 32'h0001);
      if (P == 1) chk_eq("after_rst/g0 parity", 32'(last0[FL-1]), 32'd1);

      // Randomized words with random valid gating
      rnd_gate = 1'b1;
      for (int i = 0; i < 150; i++) begin
         src0.push_back(W'($urandom));
         src1.push_back(W'($urandom));
      end
      run_until_idle("random", 20000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
